inst_fetch_resp: RTL and testbench

- Responder side of the PC fetch interface. Accepts the fetch address `pc_i` and enable `ce_i` from the PC register and returns a 32-bit instruction.
- The instruction is assembled from a byte-wide external instruction ROM port, using a one-word hit buffer.
- `stallreq_o` goes to CTRL while a word is being assembled, so CTRL holds the PC (`stall[0]`) until the instruction is ready.

---
 rtl/inst_fetch_resp_pkg.sv | 23 ++
 rtl/inst_byte_asm.sv | 35 +++
 rtl/inst_fetch_resp.sv | 120 ++++++++++++
 tb/tb_inst_fetch_resp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_resp_pkg.sv
// Shared defines for the instruction fetch responder: chip/reset levels,
// instruction bus sizing and the fetch FSM state type.
package inst_fetch_resp_pkg;

    localparam logic ChipEnable   = 1'b1;
    localparam logic ChipDisable  = 1'b0;
    localparam logic RstEnable    = 1'b1;

    localparam int          InstBusW     = 32;
    localparam int          InstAddrBusW = 32;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    typedef enum logic {
        IDLE,
        FETCH
    } fetch_state_t;

    // Bit offset of a byte lane inside the instruction word.
    function automatic logic [4:0] lane_base(input logic [1:0] lane, input logic big_endian);
        return big_endian ? {~lane, 3'b000} : {lane, 3'b000};
    endfunction

endpackage

// File: rtl/inst_byte_asm.sv
// Four-lane byte assembler: drops one ROM byte per load into the lane
// chosen by the byte counter, in big- or little-endian order.
module inst_byte_asm
    import inst_fetch_resp_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [1:0]          lane,
    input  logic [7:0]          byte_in,
    output logic [InstBusW-1:0] word_next
);

    logic [InstBusW-1:0] word_q;

    // word_next already contains the byte arriving this cycle, so the
    // top level can capture a complete word on the final ack edge.
    always_comb begin
        word_next = word_q;
        if (load) begin
            word_next[lane_base(lane, BIG_ENDIAN) +: 8] = byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            word_q <= ZeroWord;
        end else begin
            word_q <= word_next;
        end
    end

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder: serves 32-bit instructions from a one-word
// hit buffer, refilling it byte by byte from the ROM port on a miss.
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int ADDR_W     = InstAddrBusW,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                ce_i,
    output logic [InstBusW-1:0] inst_o,
    output logic                stallreq_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_rd_o,
    input  logic [7:0]          mem_data_i,
    input  logic                mem_ack_i
);

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic                buf_valid;
    logic [ADDR_W-1:2]   buf_addr;
    logic [InstBusW-1:0] buf_data;
    logic [ADDR_W-1:2]   fetch_addr;
    logic [1:0]          cnt;
    logic                hit;
    logic                start_fetch;
    logic                byte_load;
    logic [InstBusW-1:0] asm_word;

    assign hit         = (ce_i == ChipEnable) & buf_valid & (buf_addr == pc_i[ADDR_W-1:2]);
    assign inst_o      = hit ? buf_data : ZeroWord;
    assign stallreq_o  = (ce_i == ChipEnable) & ~hit;
    assign start_fetch = (state == IDLE) & stallreq_o;
    assign byte_load   = (state == FETCH) & (ce_i == ChipEnable) & mem_rd_o & mem_ack_i;

    inst_byte_asm #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_byte_asm (
        .clk       (clk),
        .rst       (rst),
        .load      (byte_load),
        .lane      (cnt),
        .byte_in   (mem_data_i),
        .word_next (asm_word)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A disabled chip aborts a fetch even if the ROM acks in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_fetch) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (ce_i == ChipDisable) begin
                    state_next = IDLE;
                end else if (mem_ack_i && cnt == 2'd3) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The low offset bits of pc_i are masked so every fetch starts word-aligned.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= ZeroWord;
            fetch_addr <= '0;
            cnt        <= 2'd0;
            mem_rd_o   <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fetch) begin
                        fetch_addr <= pc_i[ADDR_W-1:2];
                        mem_addr_o <= {pc_i[ADDR_W-1:2], pc_i[1:0] & 2'b00};
                        cnt        <= 2'd0;
                        mem_rd_o   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (ce_i == ChipDisable) begin
                        mem_rd_o <= 1'b0;
                    end else if (mem_ack_i) begin
                        if (cnt == 2'd3) begin
                            buf_data  <= asm_word;
                            buf_addr  <= fetch_addr;
                            buf_valid <= 1'b1;
                            mem_rd_o  <= 1'b0;
                        end else begin
                            cnt        <= cnt + 2'd1;
                            mem_addr_o <= {fetch_addr, cnt + 2'd1};
                        end
                    end
                end
                default: begin
                    mem_rd_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Self-checking bench for inst_fetch_resp: a behavioural byte ROM with
// configurable wait states drives a big-endian and a little-endian instance.
module tb_inst_fetch_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic [7:0]  mem_data_i;
    logic        mem_ack_i;

    logic [31:0] inst_o, inst_le;
    logic        stallreq_o, stall_le;
    logic [31:0] mem_addr_o, mem_addr_le;
    logic        mem_rd_o, rd_le;

    logic [7:0]  rom [0:63];
    int          wait_cycles = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic [31:0] exp_inst;
        logic        exp_stall;
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] addr_q[$];
    vec_t        vecs[6];

    always #5 clk = ~clk;

    inst_fetch_resp #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .inst_o     (inst_o),
        .stallreq_o (stallreq_o),
        .mem_addr_o (mem_addr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    inst_fetch_resp #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .inst_o     (inst_le),
        .stallreq_o (stall_le),
        .mem_addr_o (mem_addr_le),
        .mem_rd_o   (rd_le),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    // ROM responder: inserts wait_cycles idle cycles before every ack.
    initial begin
        int wcnt;
        wcnt       = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_rd_o) begin
                if (wcnt < wait_cycles) begin
                    mem_ack_i = 1'b0;
                    wcnt++;
                end else begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = rom[mem_addr_o[5:0]];
                    wcnt       = 0;
                end
            end else begin
                mem_ack_i = 1'b0;
                wcnt      = 0;
            end
        end
    end

    // Log the byte address of every ROM transfer the design actually accepts.
    always @(posedge clk) begin
        if (mem_rd_o && mem_ack_i && ce_i && !rst) begin
            addr_q.push_back(mem_addr_o);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Launch a miss at pc, wait for the stall to clear and score the result.
    task automatic run_fetch(input logic [31:0] pc, input int waits, input string name);
        exp_t        e;
        int          stalls;
        logic [5:0]  base;
        base        = {pc[5:2], 2'b00};
        wait_cycles = waits;
        addr_q.delete();
        @(negedge clk);
        pc_i = pc;
        ce_i = 1'b1;
        e.addr = {pc[31:2], 2'b00};
        e.word = {rom[base], rom[base + 6'd1], rom[base + 6'd2], rom[base + 6'd3]};
        sb_q.push_back(e);
        stalls = 0;
        #1;
        while (stallreq_o && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check_output({name, " stall cycles"}, stalls, 1 + 4 * (waits + 1));
        e = sb_q.pop_front();
        check_output({name, " inst big-endian"}, inst_o, e.word);
        check_output({name, " inst little-endian"}, inst_le,
                     {e.word[7:0], e.word[15:8], e.word[23:16], e.word[31:24]});
        check_output({name, " byte transfers"}, addr_q.size(), 4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
            check_output($sformatf("%s byte addr %0d", name, i), addr_q[i], e.addr + i);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        @(negedge clk);
        pc_i = v.pc;
        ce_i = v.ce;
        #1;
        check_output($sformatf("vec%0d inst", idx), inst_o, v.exp_inst);
        check_output($sformatf("vec%0d stall", idx), stallreq_o, v.exp_stall);
        check_output($sformatf("vec%0d mem_rd", idx), mem_rd_o, 1'b0);
        ce_i = 1'b0;
    endtask

    initial begin
        int cyc;
        rst  = 1'b1;
        ce_i = 1'b0;
        pc_i = 32'h0;
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        rom[0]  = 8'h34; rom[1]  = 8'h01; rom[2]  = 8'h11; rom[3]  = 8'h00;
        rom[4]  = 8'hAA; rom[5]  = 8'hBB; rom[6]  = 8'hCC; rom[7]  = 8'hDD;
        rom[8]  = 8'h11; rom[9]  = 8'h22; rom[10] = 8'h33; rom[11] = 8'h44;
        rom[16] = 8'h5A; rom[17] = 8'hA5; rom[18] = 8'hC3; rom[19] = 8'h3C;

        repeat (2) @(negedge clk);
        #1;
        check_output("reset inst", inst_o, 32'h0);
        check_output("reset stall", stallreq_o, 1'b0);
        check_output("reset mem_rd", mem_rd_o, 1'b0);
        check_output("reset mem_addr", mem_addr_o, 32'h0);
        check_output("reset mem_addr le", mem_addr_le, 32'h0);
        rst = 1'b0;

        // Cold miss at 0 with a zero-wait ROM.
        run_fetch(32'h0000_0000, 0, "t1");
        check_output("t1 inst const", inst_o, 32'h3401_1100);

        // Hits, offset addresses, disabled chip and misses against the buffer.
        vecs[0] = '{pc: 32'h0000_0000, ce: 1'b1, exp_inst: 32'h3401_1100, exp_stall: 1'b0};
        vecs[1] = '{pc: 32'h0000_0002, ce: 1'b1, exp_inst: 32'h3401_1100, exp_stall: 1'b0};
        vecs[2] = '{pc: 32'h0000_0003, ce: 1'b1, exp_inst: 32'h3401_1100, exp_stall: 1'b0};
        vecs[3] = '{pc: 32'h0000_0000, ce: 1'b0, exp_inst: 32'h0000_0000, exp_stall: 1'b0};
        vecs[4] = '{pc: 32'h0000_0004, ce: 1'b1, exp_inst: 32'h0000_0000, exp_stall: 1'b1};
        vecs[5] = '{pc: 32'h8000_0000, ce: 1'b1, exp_inst: 32'h0000_0000, exp_stall: 1'b1};
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Two wait states before every ack.
        run_fetch(32'h0000_0004, 2, "t3");
        check_output("t3 inst const", inst_o, 32'hAABB_CCDD);
        check_output("t3 inst le const", inst_le, 32'hDDCC_BBAA);

        // Abort after two accepted bytes; the old word must survive.
        wait_cycles = 0;
        addr_q.delete();
        @(negedge clk);
        pc_i = 32'h0000_0008;
        ce_i = 1'b1;
        cyc  = 0;
        while (addr_q.size() < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_output("t4 bytes before abort", addr_q.size(), 2);
        ce_i = 1'b0;
        @(negedge clk);
        #1;
        check_output("t4 abort mem_rd", mem_rd_o, 1'b0);
        check_output("t4 abort inst", inst_o, 32'h0);
        check_output("t4 abort stall", stallreq_o, 1'b0);
        pc_i = 32'h0000_0004;
        ce_i = 1'b1;
        #1;
        check_output("t4 old word kept", inst_o, 32'hAABB_CCDD);
        check_output("t4 old word stall", stallreq_o, 1'b0);
        run_fetch(32'h0000_0008, 0, "t4 restart");

        // Reset in the middle of a fetch clears the buffer.
        wait_cycles = 0;
        addr_q.delete();
        @(negedge clk);
        pc_i = 32'h0000_0000;
        ce_i = 1'b1;
        cyc  = 0;
        while (addr_q.size() < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_output("t5 bytes before reset", addr_q.size(), 2);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        pc_i = 32'h0000_0008;
        #1;
        check_output("t5 reset mem_rd", mem_rd_o, 1'b0);
        check_output("t5 reset mem_addr", mem_addr_o, 32'h0);
        check_output("t5 buffer invalid stall", stallreq_o, 1'b1);
        check_output("t5 buffer invalid inst", inst_o, 32'h0);
        ce_i = 1'b0;
        run_fetch(32'h0000_0000, 0, "t5 refetch");

        // Single-entry buffer: alternating words always miss.
        run_fetch(32'h0000_0010, 0, "t6 a");
        run_fetch(32'h0000_0000, 0, "t6 b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
